vec_mul_sequencer: RTL and testbench

- Control FSM for the 16x16 vector-multiplier top.
- On `start`, it pops one weight set from the weight FIFO and pulses `weight_reload` to the array.
- It then streams `vec_count` input vectors from the unified buffer, one per cycle, and writes each result to the result SRAM after the fixed array latency.
- It replaces the free-running counter and valid glue with one sequenced, restartable controller.

---
 rtl/vec_mul_pkg.sv | 18 +
 rtl/vec_mul_sequencer_valid_delay_line.sv | 33 +++
 rtl/vec_mul_sequencer.sv | 146 ++++++++++++++
 tb/tb_vec_mul_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_mul_pkg.sv
// Shared types and default sizing for the 16x16 vector-multiplier control path.
package vec_mul_pkg;

    localparam int unsigned DEF_ADDRESSSIZE  = 10;
    localparam int unsigned DEF_PIPE_LATENCY = 17;
    localparam int unsigned DEF_CNT_BW       = 11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_W = 3'd1,
        POP    = 3'd2,
        RELOAD = 3'd3,
        STREAM = 3'd4,
        DRAIN  = 3'd5,
        FINISH = 3'd6
    } seq_state_t;

endpackage

// File: rtl/vec_mul_sequencer_valid_delay_line.sv
// Fixed-depth 1-bit valid shift register with synchronous clear.
// any_set flags entries still travelling upstream of the output stage.
module valid_delay_line #(
    parameter int unsigned DEPTH = 17
) (
    input  logic clk,
    input  logic clr,
    input  logic din,
    output logic dout,
    output logic any_set
);

    logic [DEPTH-1:0] sr;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (clr) sr <= '0;
                else     sr <= din;
            end
            assign any_set = 1'b0;
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (clr) sr <= '0;
                else     sr <= {sr[DEPTH-2:0], din};
            end
            assign any_set = |sr[DEPTH-2:0];
        end
    endgenerate

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/vec_mul_sequencer.sv
// Run controller for the 16x16 vector multiplier: weight pop/reload, vector
// issue, delayed result writes. SEQ_PERF_COUNTER_EN adds the run_cycles port.
module vec_mul_sequencer
    import vec_mul_pkg::*;
#(
    parameter int unsigned ADDRESSSIZE  = DEF_ADDRESSSIZE,
    parameter int unsigned PIPE_LATENCY = DEF_PIPE_LATENCY,
    parameter int unsigned CNT_BW       = DEF_CNT_BW
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [ADDRESSSIZE-1:0] base_addr,
    input  logic [CNT_BW-1:0]      vec_count,
    input  logic                   fifo_empty,
    output logic                   fifo_read_enable,
    output logic                   weight_reload,
    output logic [ADDRESSSIZE-1:0] ub_address,
    output logic                   ub_read_valid,
    output logic                   res_write_enable,
    output logic [ADDRESSSIZE-1:0] res_write_addr,
    output logic                   busy,
    output logic                   done
`ifdef SEQ_PERF_COUNTER_EN
    ,
    output logic [31:0]            run_cycles
`endif
);

    seq_state_t             state_q, state_d;
    logic [ADDRESSSIZE-1:0] base_q, base_d;
    logic [CNT_BW-1:0]      count_q, count_d;
    logic [CNT_BW-1:0]      issue_q, issue_d;
    logic [CNT_BW-1:0]      wr_cnt_q, wr_cnt_d;
    logic [ADDRESSSIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDRESSSIZE-1:0] ub_address_d;
    logic                   in_flight;
    logic                   writes_done;
    logic [CNT_BW-1:0]      last_idx;
    logic                   dl_clr;

    assign dl_clr         = ~rstn;
    assign last_idx       = count_q - CNT_BW'(1);
    assign writes_done    = (wr_cnt_q + CNT_BW'(res_write_enable)) == count_q;
    assign res_write_addr = wr_addr_q;

    // Valid travels alongside the array pipeline; its tail is the write strobe.
    valid_delay_line #(
        .DEPTH (PIPE_LATENCY)
    ) u_valid_delay (
        .clk     (clk),
        .clr     (dl_clr),
        .din     (ub_read_valid),
        .dout    (res_write_enable),
        .any_set (in_flight)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        count_d   = count_q;
        issue_d   = issue_q;
        wr_cnt_d  = wr_cnt_q;
        wr_addr_d = wr_addr_q;

        if (res_write_enable) begin
            wr_cnt_d  = wr_cnt_q + CNT_BW'(1);
            wr_addr_d = wr_addr_q + ADDRESSSIZE'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d    = base_addr;
                    count_d   = vec_count;
                    issue_d   = '0;
                    wr_cnt_d  = '0;
                    wr_addr_d = '0;
                    state_d   = (vec_count == '0) ? FINISH : WAIT_W;
                end
            end
            WAIT_W: if (!fifo_empty) state_d = POP;
            POP:    state_d = RELOAD;
            RELOAD: begin
                state_d = STREAM;
                issue_d = '0;
            end
            STREAM: begin
                if (issue_q == last_idx) state_d = DRAIN;
                else                     issue_d = issue_q + CNT_BW'(1);
            end
            // Leave once the write landing now is the last one owed.
            DRAIN:  if (!in_flight && writes_done) state_d = FINISH;
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ub_address_d = (state_d == STREAM) ? base_d + ADDRESSSIZE'(issue_d) : '0;
    end

    // State, run context and registered Moore outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q          <= IDLE;
            base_q           <= '0;
            count_q          <= '0;
            issue_q          <= '0;
            wr_cnt_q         <= '0;
            wr_addr_q        <= '0;
            fifo_read_enable <= 1'b0;
            weight_reload    <= 1'b0;
            ub_address       <= '0;
            ub_read_valid    <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            state_q          <= state_d;
            base_q           <= base_d;
            count_q          <= count_d;
            issue_q          <= issue_d;
            wr_cnt_q         <= wr_cnt_d;
            wr_addr_q        <= wr_addr_d;
            fifo_read_enable <= (state_d == POP);
            weight_reload    <= (state_d == RELOAD);
            ub_address       <= ub_address_d;
            ub_read_valid    <= (state_d == STREAM);
            busy             <= (state_d != IDLE);
            done             <= (state_d == FINISH);
        end
    end

`ifdef SEQ_PERF_COUNTER_EN
    // Counts every non-IDLE clock of the run, held in IDLE, saturating.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            run_cycles <= '0;
        end else if (state_q == IDLE) begin
            if (start) run_cycles <= '0;
        end else if (run_cycles != '1) begin
            run_cycles <= run_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vec_mul_sequencer.sv
// Scoreboard bench for vec_mul_sequencer: issue/write events are queued when a
// run is launched and retired as the DUT produces them.
module tb_vec_mul_sequencer;

    localparam int unsigned AW = 10;
    localparam int unsigned CW = 11;
    localparam int unsigned L  = 17;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] vec_count;
    logic          fifo_empty;
    logic          fifo_read_enable;
    logic          weight_reload;
    logic [AW-1:0] ub_address;
    logic          ub_read_valid;
    logic          res_write_enable;
    logic [AW-1:0] res_write_addr;
    logic          busy;
    logic          done;
`ifdef SEQ_PERF_COUNTER_EN
    logic [31:0]   run_cycles;
`endif

    vec_mul_sequencer #(
        .ADDRESSSIZE  (AW),
        .PIPE_LATENCY (L),
        .CNT_BW       (CW)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .start            (start),
        .base_addr        (base_addr),
        .vec_count        (vec_count),
        .fifo_empty       (fifo_empty),
        .fifo_read_enable (fifo_read_enable),
        .weight_reload    (weight_reload),
        .ub_address       (ub_address),
        .ub_read_valid    (ub_read_valid),
        .res_write_enable (res_write_enable),
        .res_write_addr   (res_write_addr),
        .busy             (busy),
        .done             (done)
`ifdef SEQ_PERF_COUNTER_EN
        ,
        .run_cycles       (run_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int addr;
    } ev_t;

    ev_t iq[$];
    ev_t wq[$];
    int  cyc       = 0;
    int  pop_cyc   = -1;
    int  rel_cyc   = -1;
    int  done_cyc  = -1;
    int  busy_lo   = -1;
    int  busy_hi   = -2;
    int  done_seen = 0;
    int  passed    = 0;
    int  total     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    endtask

    // Expected timeline of a run accepted at the end of cycle a.
    task automatic plan_run(input int a, input int base, input int n, input int stall);
        int first;
        iq.delete();
        wq.delete();
        if (n == 0) begin
            pop_cyc  = -1;
            rel_cyc  = -1;
            done_cyc = a + 1;
        end else begin
            pop_cyc  = a + 2 + stall;
            rel_cyc  = a + 3 + stall;
            first    = a + 4 + stall;
            for (int k = 0; k < n; k++) begin
                iq.push_back('{cyc: first + k, addr: (base + k) % 1024});
                wq.push_back('{cyc: first + k + int'(L), addr: k % 1024});
            end
            done_cyc = first + n + int'(L);
        end
        busy_lo = a + 1;
        busy_hi = done_cyc;
    endtask

    task automatic clear_plan();
        iq.delete();
        wq.delete();
        pop_cyc  = -1;
        rel_cyc  = -1;
        done_cyc = -1;
        busy_lo  = -1;
        busy_hi  = -2;
    endtask

    task automatic check_cycle();
        logic exp_iv, exp_wv;
        exp_iv = (iq.size() > 0) && (iq[0].cyc == cyc);
        exp_wv = (wq.size() > 0) && (wq[0].cyc == cyc);
        chk("ub_read_valid", 32'(ub_read_valid), 32'(exp_iv));
        if (exp_iv) begin
            chk("ub_address", 32'(ub_address), 32'(iq[0].addr));
            void'(iq.pop_front());
        end
        chk("res_write_enable", 32'(res_write_enable), 32'(exp_wv));
        if (exp_wv) begin
            chk("res_write_addr", 32'(res_write_addr), 32'(wq[0].addr));
            void'(wq.pop_front());
        end
        chk("fifo_read_enable", 32'(fifo_read_enable), 32'(cyc == pop_cyc));
        chk("weight_reload", 32'(weight_reload), 32'(cyc == rel_cyc));
        chk("done", 32'(done), 32'(cyc == done_cyc));
        chk("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
        if (done) done_seen++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rstn) check_cycle();
    endtask

    task automatic launch(input int base, input int n, input int stall);
        base_addr = AW'(base);
        vec_count = CW'(n);
        start     = 1'b1;
        plan_run(cyc, base, n, stall);
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_done_plus(input int extra);
        int stop_at;
        stop_at = done_cyc + extra;
        while (cyc < stop_at) tick();
        chk("issue_queue_drained", 32'(iq.size()), 32'd0);
        chk("write_queue_drained", 32'(wq.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_fifo_read_enable"}, 32'(fifo_read_enable), 32'd0);
        chk({tag, "_weight_reload"}, 32'(weight_reload), 32'd0);
        chk({tag, "_ub_address"}, 32'(ub_address), 32'd0);
        chk({tag, "_ub_read_valid"}, 32'(ub_read_valid), 32'd0);
        chk({tag, "_res_write_enable"}, 32'(res_write_enable), 32'd0);
        chk({tag, "_res_write_addr"}, 32'(res_write_addr), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int stop_at;
        rstn       = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        vec_count  = '0;
        fifo_empty = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
`ifdef SEQ_PERF_COUNTER_EN
        chk("reset_run_cycles", run_cycles, 32'd0);
`endif
        rstn = 1'b1;
        tick();

        // Basic run: 16 vectors from address 0.
        done_seen = 0;
        launch(0, 16, 0);
        run_to_done_plus(3);
        chk("basic_done_count", 32'(done_seen), 32'd1);
`ifdef SEQ_PERF_COUNTER_EN
        chk("basic_run_cycles", run_cycles, 32'd37);
`endif

        // Weight FIFO empty for the first 5 WAIT_W cycles.
        fifo_empty = 1'b1;
        launch(100, 3, 5);
        for (int i = 0; i < 5; i++) tick();
        fifo_empty = 1'b0;
        run_to_done_plus(2);

        // Address wrap at the top of the UB.
        launch(1022, 4, 0);
        run_to_done_plus(2);

        // Zero-length run held back-to-back into a second run.
        done_seen = 0;
        launch(7, 0, 0);
        chk("zero_len_done_next", 32'(done), 32'd1);
        start     = 1'b1;
        base_addr = AW'(20);
        vec_count = CW'(2);
        tick();
        plan_run(cyc, 20, 2, 0);
        tick();
        start = 1'b0;
        run_to_done_plus(2);
        chk("zero_len_then_run_dones", 32'(done_seen), 32'd2);

        // Reset asserted while issue_idx 5 is on the bus.
        launch(0, 16, 0);
        stop_at = cyc + 8;
        while (cyc < stop_at) tick();
        chk("pre_reset_ub_address", 32'(ub_address), 32'd5);
        rstn = 1'b0;
        clear_plan();
        tick();
        check_all_zero("midrun_reset");
        rstn = 1'b1;
        for (int i = 0; i < 25; i++) tick();

        // Fresh run after reset, with start pulses during DRAIN ignored.
        done_seen = 0;
        launch(50, 16, 0);
        stop_at = cyc + 24;
        while (cyc < stop_at) tick();
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        run_to_done_plus(10);
        chk("busy_start_done_count", 32'(done_seen), 32'd1);
`ifdef SEQ_PERF_COUNTER_EN
        chk("busy_start_run_cycles", run_cycles, 32'd37);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
